lcd_pattern_gen: RTL
====================

LCD_PATTERN_GEN -- requirements
Module: lcd_pattern_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 480, active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 272, active lines per frame.
REQ-003 SHALL have parameter VS_POL, default 0, asserted level of vs_i.
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 180000, key stable time (20 ms at 9 MHz).
REQ-005 SHALL have port clk, input, 1, pixel clock.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port hs_i, vs_i, de_i, input, 1 each, timing from the upstream timing generator.
REQ-008 SHALL have port active_x, active_y, input, 10 each, pixel position, valid while de_i=1.
REQ-009 SHALL have port key_n, input, 1, asynchronous active-low mode button.
REQ-010 SHALL have port hs_o, vs_o, de_o, output, 1 each, timing delayed to align with colour.
REQ-011 SHALL have port lcd_r, output, 5, and lcd_g, output, 6, and lcd_b, output, 5, RGB565 pixel.
REQ-012 SHALL have port mode, output, 2, currently displayed pattern.

Function
REQ-013 SHALL delay hs_i, vs_i, de_i by exactly 2 clk to hs_o, vs_o, de_o; colour for input cycle N appears on lcd_* at cycle N+2.
REQ-014 SHALL drive lcd_r/g/b to 0 on every cycle de_o=0.
REQ-015 SHALL implement mode 0, colour bars: bar index = active_x/(H_ACTIVE/8) via comparisons, colours white, yellow, cyan, green, magenta, red, blue, black left to right.
REQ-016 SHALL implement mode 1, grid: white when active_x[4:0]==0, active_y[4:0]==0, active_x==H_ACTIVE-1 or active_y==V_ACTIVE-1; black otherwise.
REQ-017 SHALL implement mode 2, gradient: lcd_r=active_x[8:4], lcd_g=active_y[8:3], lcd_b=~active_x[8:4].
REQ-018 SHALL implement mode 3, moving box: white 32x32 square at (box_x, box_y) over dark blue (r=0,g=0,b=8).
REQ-019 SHALL detect frame start as vs_i transition from not-VS_POL to VS_POL, one registered cycle later.
REQ-020 SHALL update box position once per frame start: step 1 pixel on each axis; box_x range 0..H_ACTIVE-32, box_y range 0..V_ACTIVE-32.
REQ-021 SHALL reverse axis direction at a range limit: at max moving right, next value max-1 and direction left; at 0 moving left, next value 1 and direction right; same rule vertically.
REQ-022 SHALL synchronise key_n with 2 flops, then accept a level only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-023 SHALL generate one press event on debounced high-to-low transition; releases generate nothing.
REQ-024 SHALL increment pending mode on each press, wrapping 3 to 0.
REQ-025 SHALL copy pending mode to mode only at frame start; multiple presses within one frame SHALL all accumulate.
REQ-026 SHALL, if press and frame start coincide, apply the pre-press pending value at that frame start and carry the increment to the next.
REQ-027 SHALL hold box position and directions unchanged while mode!=3.

Reset
REQ-028 SHALL on rst clear all pipeline registers: hs_o=0, vs_o=0, de_o=0, lcd_*=0.
REQ-029 SHALL on rst set mode=0, pending mode=0, box_x=0, box_y=0, directions right/down, debounced key=1, debounce counter=0.
REQ-030 SHALL, on reset asserted mid-frame, resume correct output from the first cycle after release, aligned to upstream timing with 2-cycle latency.

Structure
REQ-031 SHALL place mode encodings, RGB565 colour constants, box size 32 and pipeline latency 2 in shared package lcd_pkg.
REQ-032 SHALL implement synchroniser plus debouncer as sub-module key_debounce, outputting the one-cycle press pulse.
REQ-033 SHALL be fully synchronous to clk apart from the asynchronous rst.

Verification
REQ-034 SHALL verify mode 0 at active_y=10: active_x=59 -> white (31,63,31); active_x=60 -> yellow (31,63,0); two cycles later, de_o=1.
REQ-035 SHALL verify key_n low pulse of DEBOUNCE_CYCLES-1 -> no mode change; low held 2*DEBOUNCE_CYCLES mid-frame -> mode stays 0 until next frame start, then 1.
REQ-036 SHALL verify mode 3 over 450 frames -> box_x reaches 448 on frame 448, equals 447 on frame 449; box_y peaks at 240 and reverses.
REQ-037 SHALL verify active_x=31, active_y=5 in mode 1 -> black; active_x=32 -> white; de_i=0 -> lcd_*=0.
REQ-038 SHALL verify rst asserted at active line 100 -> outputs 0 immediately, mode=0; after release, pattern matches model with latency 2.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD test-pattern generator.
// Holds the pattern mode encodings, the RGB565 pixel type with its colour
// constants, the moving-box size and the colour pipeline latency.
package lcd_pkg;

    typedef enum logic [1:0] {
        MODE_BARS     = 2'd0,
        MODE_GRID     = 2'd1,
        MODE_GRADIENT = 2'd2,
        MODE_BOX      = 2'd3
    } mode_e;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    localparam rgb565_t RGB_WHITE     = '{r: 5'd31, g: 6'd63, b: 5'd31};
    localparam rgb565_t RGB_YELLOW    = '{r: 5'd31, g: 6'd63, b: 5'd0};
    localparam rgb565_t RGB_CYAN      = '{r: 5'd0,  g: 6'd63, b: 5'd31};
    localparam rgb565_t RGB_GREEN     = '{r: 5'd0,  g: 6'd63, b: 5'd0};
    localparam rgb565_t RGB_MAGENTA   = '{r: 5'd31, g: 6'd0,  b: 5'd31};
    localparam rgb565_t RGB_RED       = '{r: 5'd31, g: 6'd0,  b: 5'd0};
    localparam rgb565_t RGB_BLUE      = '{r: 5'd0,  g: 6'd0,  b: 5'd31};
    localparam rgb565_t RGB_BLACK     = '{r: 5'd0,  g: 6'd0,  b: 5'd0};
    localparam rgb565_t RGB_DARK_BLUE = '{r: 5'd0,  g: 6'd0,  b: 5'd8};

    localparam int BOX_SIZE     = 32;
    localparam int PIPE_LATENCY = 2;

    // Colour-bar palette, left (0) to right (7).
    function automatic rgb565_t bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_colour = RGB_WHITE;
            3'd1:    bar_colour = RGB_YELLOW;
            3'd2:    bar_colour = RGB_CYAN;
            3'd3:    bar_colour = RGB_GREEN;
            3'd4:    bar_colour = RGB_MAGENTA;
            3'd5:    bar_colour = RGB_RED;
            3'd6:    bar_colour = RGB_BLUE;
            default: bar_colour = RGB_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Mode-button synchroniser and debouncer.
// Ports:
//   clk, rst  - pixel clock, asynchronous active-high reset
//   key_n     - raw active-low button, asynchronous to clk
//   press     - one-cycle pulse on a debounced high-to-low transition
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 180000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync_1;
    logic             sync_2;
    logic             key_db;
    logic [CNT_W-1:0] stable_cnt;

    // NOTE: state registers take the asynchronous reset in the sensitivity
    // list; the reset branch sets every register the block assigns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1     <= 1'b1;
            sync_2     <= 1'b1;
            key_db     <= 1'b1;
            stable_cnt <= '0;
            press      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let sync_2 sample the old sync_1,
            // giving a true two-flop chain regardless of statement order.
            sync_1 <= key_n;
            sync_2 <= sync_1;
            press  <= 1'b0;
            // Count consecutive samples that disagree with the accepted level;
            // the DEBOUNCE_CYCLES-th one in a row is accepted.
            if (sync_2 == key_db) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                key_db     <= sync_2;
                stable_cnt <= '0;
                press      <= ~sync_2;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_pattern_gen.sv
// LCD test-pattern generator: colour bars, grid, gradient and a bouncing box.
// Ports:
//   clk, rst                 - pixel clock, asynchronous active-high reset
//   hs_i, vs_i, de_i         - upstream sync / data-enable
//   active_x, active_y       - pixel position, valid while de_i=1
//   key_n                    - active-low mode button (asynchronous)
//   hs_o, vs_o, de_o         - timing delayed by PIPE_LATENCY clocks
//   lcd_r, lcd_g, lcd_b      - RGB565 pixel aligned with de_o, 0 when blanked
//   mode                     - pattern currently displayed
module lcd_pattern_gen
    import lcd_pkg::*;
#(
    parameter int H_ACTIVE        = 480,
    parameter int V_ACTIVE        = 272,
    parameter bit VS_POL          = 1'b0,
    parameter int DEBOUNCE_CYCLES = 180000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hs_i,
    input  logic       vs_i,
    input  logic       de_i,
    input  logic [9:0] active_x,
    input  logic [9:0] active_y,
    input  logic       key_n,
    output logic       hs_o,
    output logic       vs_o,
    output logic       de_o,
    output logic [4:0] lcd_r,
    output logic [5:0] lcd_g,
    output logic [4:0] lcd_b,
    output logic [1:0] mode
);

    localparam int         BAR_W     = H_ACTIVE / 8;
    localparam logic [9:0] X_LAST    = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST    = 10'(V_ACTIVE - 1);
    localparam logic [9:0] BOX_X_MAX = 10'(H_ACTIVE - BOX_SIZE);
    localparam logic [9:0] BOX_Y_MAX = 10'(V_ACTIVE - BOX_SIZE);

    logic       press;
    logic       vs_prev;
    logic       frame_start;
    mode_e      mode_q;
    logic [1:0] pending_q;
    logic [9:0] box_x;
    logic [9:0] box_y;
    logic       dir_right;
    logic       dir_down;

    logic [2:0] bar_idx;
    logic       on_grid;
    logic       in_box;
    rgb565_t    pix_colour;

    logic       hs_s1, vs_s1, de_s1;
    rgb565_t    colour_s1;
    rgb565_t    colour_s2;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_n),
        .press (press)
    );

    // Frame start: registered pulse one cycle after vs_i enters its asserted level.
    // vs_prev resets to the asserted level so a vs already active at reset
    // release is not taken as a new frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_prev     <= VS_POL;
            frame_start <= 1'b0;
        end else begin
            vs_prev     <= vs_i;
            frame_start <= (vs_i == VS_POL) && (vs_prev != VS_POL);
        end
    end

    // Mode selection and box motion. A press coinciding with frame_start
    // increments pending_q while mode_q takes the pre-press value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= MODE_BARS;
            pending_q <= 2'd0;
            box_x     <= '0;
            box_y     <= '0;
            dir_right <= 1'b1;
            dir_down  <= 1'b1;
        end else begin
            if (press) pending_q <= pending_q + 2'd1;
            if (frame_start) begin
                mode_q <= mode_e'(pending_q);
                if (mode_q == MODE_BOX) begin
                    if (dir_right) begin
                        if (box_x == BOX_X_MAX) begin
                            box_x     <= BOX_X_MAX - 10'd1;
                            dir_right <= 1'b0;
                        end else begin
                            box_x <= box_x + 10'd1;
                        end
                    end else if (box_x == 10'd0) begin
                        box_x     <= 10'd1;
                        dir_right <= 1'b1;
                    end else begin
                        box_x <= box_x - 10'd1;
                    end
                    if (dir_down) begin
                        if (box_y == BOX_Y_MAX) begin
                            box_y    <= BOX_Y_MAX - 10'd1;
                            dir_down <= 1'b0;
                        end else begin
                            box_y <= box_y + 10'd1;
                        end
                    end else if (box_y == 10'd0) begin
                        box_y    <= 10'd1;
                        dir_down <= 1'b1;
                    end else begin
                        box_y <= box_y - 10'd1;
                    end
                end
            end
        end
    end

    // Pixel colour for the current input position.
    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        bar_idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (active_x >= 10'(i * BAR_W)) bar_idx = 3'(i);
        end

        on_grid = (active_x[4:0] == 5'd0) || (active_y[4:0] == 5'd0) ||
                  (active_x == X_LAST)    || (active_y == Y_LAST);

        // 11-bit compare keeps box_x + BOX_SIZE from wrapping.
        in_box = (active_x >= box_x) &&
                 ({1'b0, active_x} < ({1'b0, box_x} + 11'(BOX_SIZE))) &&
                 (active_y >= box_y) &&
                 ({1'b0, active_y} < ({1'b0, box_y} + 11'(BOX_SIZE)));

        pix_colour = RGB_BLACK;
        case (mode_q)
            MODE_BARS:     pix_colour = bar_colour(bar_idx);
            MODE_GRID:     pix_colour = on_grid ? RGB_WHITE : RGB_BLACK;
            MODE_GRADIENT: pix_colour = '{r: active_x[8:4], g: active_y[8:3], b: ~active_x[8:4]};
            MODE_BOX:      pix_colour = in_box ? RGB_WHITE : RGB_DARK_BLUE;
            default:       pix_colour = RGB_BLACK;
        endcase
    end

    // Two-stage output pipeline; colour is blanked at stage 1 so it travels
    // with de and is zero whenever de_o is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_s1     <= 1'b0;
            vs_s1     <= 1'b0;
            de_s1     <= 1'b0;
            colour_s1 <= RGB_BLACK;
            hs_o      <= 1'b0;
            vs_o      <= 1'b0;
            de_o      <= 1'b0;
            colour_s2 <= RGB_BLACK;
        end else begin
            hs_s1     <= hs_i;
            vs_s1     <= vs_i;
            de_s1     <= de_i;
            colour_s1 <= de_i ? pix_colour : RGB_BLACK;
            hs_o      <= hs_s1;
            vs_o      <= vs_s1;
            de_o      <= de_s1;
            colour_s2 <= colour_s1;
        end
    end

    assign lcd_r = colour_s2.r;
    assign lcd_g = colour_s2.g;
    assign lcd_b = colour_s2.b;
    assign mode  = mode_q;

endmodule
